// File: rtl/pinky_pkg.sv
// Shared encodings for the pinky fetch/decode front end: opcodes, condition
// codes, instruction field positions and the sequencer state type.
package pinky_pkg;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_SYS = 5'b10011;
  localparam logic [4:0] OP_NOP = 5'b10100;

  localparam logic [1:0] CC_AL = 2'd0;
  localparam logic [1:0] CC_S  = 2'd1;
  localparam logic [1:0] CC_NE = 2'd2;
  localparam logic [1:0] CC_EQ = 2'd3;

  localparam logic [1:0] PRE_TAG = 2'b11;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int PRE_HI  = 15;
  localparam int PRE_LO  = 14;
  localparam int CC_HI   = 10;
  localparam int CC_LO   = 9;
  localparam int IMM_BIT = 8;
  localparam int DEST_HI = 7;
  localparam int DEST_LO = 4;
  localparam int OP2_HI  = 3;
  localparam int OP2_LO  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // A conditional instruction is dropped when its condition disagrees with Z.
  function automatic logic cc_squash(input logic [1:0] cc, input logic z);
    return ((cc == CC_NE) && z) || ((cc == CC_EQ) && !z);
  endfunction

endpackage

// File: rtl/pinky_regfile.sv
// Two-read/one-write register file; the top register is never written.
// FD_FORWARD_EN: reads of the register being written return the write data.
module pinky_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       raddr_a,
  input  logic [3:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  localparam logic [3:0] LAST = 4'(NREGS - 1);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr < LAST)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
`ifdef FD_FORWARD_EN
    if (we && (waddr < LAST) && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr < LAST) && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: instruction memory, PC sequencer, PRE prefixing,
// condition squash and operand read. FD_FORWARD_EN enables write-back bypass.
module fetch_decode
  import pinky_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int IMEM_AW = 10,
  parameter int NREGS   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [WIDTH-1:0]   imem_wdata,
  input  logic               z,
  input  logic               wb_en,
  input  logic [3:0]         wb_dest,
  input  logic [WIDTH-1:0]   wb_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IMEM_AW-1:0] pc_out,
  output logic [WIDTH-1:0]   ir_out,
  output logic [WIDTH-1:0]   rd_val,
  output logic [WIDTH-1:0]   op2_val,
  output logic               halt
);

  localparam int         DEPTH = 2 ** IMEM_AW;
  localparam logic [3:0] LAST  = 4'(NREGS - 1);

  function automatic logic [WIDTH-1:0] sext4(input logic signed [3:0] v);
    return {{(WIDTH - 4){v[3]}}, v};
  endfunction

  logic [WIDTH-1:0] imem [DEPTH];

  state_t             state, state_next;
  logic [IMEM_AW-1:0] pc;
  logic [WIDTH-5:0]   pre;
  logic               pre_flag;

  logic               vld_p1;
  logic [IMEM_AW-1:0] pc_p1;
  logic [WIDTH-1:0]   ir_p1, rd_p1, op2_p1;

  logic [WIDTH-1:0]   ir_p0, pc_ext_p0, rf_a_p0, rf_b_p0;
  logic [WIDTH-1:0]   rd_p0, op2_reg_p0, op2_imm_p0;
  logic [3:0]         dest_p0, op2_p0;
  logic               is_pre_p0, kill_p0, imm_p0;
  logic               out_sys, advance, fetch;

  // Stage 0: fetch and decode from imem[pc]
  assign ir_p0      = imem[pc];
  assign dest_p0    = ir_p0[DEST_HI:DEST_LO];
  assign op2_p0     = ir_p0[OP2_HI:OP2_LO];
  assign imm_p0     = ir_p0[IMM_BIT];
  assign is_pre_p0  = (ir_p0[PRE_HI:PRE_LO] == PRE_TAG);
  assign kill_p0    = cc_squash(ir_p0[CC_HI:CC_LO], z);
  assign pc_ext_p0  = WIDTH'(pc);

  assign rd_p0      = (dest_p0 == LAST) ? pc_ext_p0 : rf_a_p0;
  assign op2_reg_p0 = (op2_p0 == LAST) ? pc_ext_p0 : rf_b_p0;
  assign op2_imm_p0 = pre_flag ? {pre, op2_p0} : sext4(op2_p0);

  assign out_sys = vld_p1 && (ir_p1[OPC_HI:OPC_LO] == OP_SYS);
  assign advance = !vld_p1 || out_ready;
  // Once SYS sits on the outputs nothing further is fetched.
  assign fetch   = (state == S_RUN) && advance && !out_sys;

  pinky_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_dest),
    .wdata   (wb_data),
    .raddr_a (dest_p0),
    .raddr_b (op2_p0),
    .rdata_a (rf_a_p0),
    .rdata_b (rf_b_p0)
  );

  always_ff @(posedge clk) begin
    if (imem_we && (state != S_RUN)) imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (out_sys && out_ready) state_next = S_HALT;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Stage 1: registered decode presented to downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      pre      <= '0;
      pre_flag <= 1'b0;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      ir_p1    <= '0;
      rd_p1    <= '0;
      op2_p1   <= '0;
    end else if (fetch) begin
      pc <= pc + 1'b1;
      if (is_pre_p0) begin
        pre      <= ir_p0[WIDTH-5:0];
        pre_flag <= 1'b1;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= 1'b1;
        pc_p1  <= pc;
        if (kill_p0) begin
          ir_p1  <= {OP_NOP, {(WIDTH - 5){1'b0}}};
          rd_p1  <= '0;
          op2_p1 <= '0;
        end else begin
          ir_p1  <= ir_p0;
          rd_p1  <= rd_p0;
          op2_p1 <= imm_p0 ? op2_imm_p0 : op2_reg_p0;
          if (imm_p0) pre_flag <= 1'b0;
        end
      end
    end else if ((state == S_RUN) && advance) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign pc_out    = pc_p1;
  assign ir_out    = ir_p1;
  assign rd_val    = rd_p1;
  assign op2_val   = op2_p1;
  assign halt      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: one task per scenario with inline checks.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_addr = '0;
  logic [15:0] imem_wdata = '0;
  logic        z = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [15:0] wb_data = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [9:0]  pc_out;
  logic [15:0] ir_out, rd_val, op2_val;
  logic        halt;

  int errors = 0;
  int checks = 0;

  fetch_decode dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .z          (z),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .rd_val     (rd_val),
    .op2_val    (op2_val),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", halt); end
    checks++; if (pc_out !== 10'h000) begin errors++; $display("FAIL reset_pc got %h want 000", pc_out); end
    checks++; if (ir_out !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want 0000", ir_out); end
    checks++; if (rd_val !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h want 0000", rd_val); end
    checks++; if (op2_val !== 16'h0000) begin errors++; $display("FAIL reset_op2 got %h want 0000", op2_val); end
  endtask

  task automatic test_mov_sys();
    do_reset();
    load(10'd0, 16'h111D);
    load(10'd1, 16'h9800);
    out_ready = 1'b1;
    start_run();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mov_valid got %b want 1", out_valid); end
    checks++; if (op2_val !== 16'hFFFD) begin errors++; $display("FAIL mov_op2 got %h want fffd", op2_val); end
    checks++; if (pc_out !== 10'd0) begin errors++; $display("FAIL mov_pc got %h want 000", pc_out); end
    tick();
    checks++; if (ir_out !== 16'h9800 || out_valid !== 1'b1) begin errors++; $display("FAIL sys_word got %h/%b want 9800/1", ir_out, out_valid); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL sys_halt_early got %b want 0", halt); end
    tick();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL sys_halt got %b want 1", halt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sys_after_valid got %b want 0", out_valid); end
  endtask

  task automatic test_pre();
    do_reset();
    load(10'd0, 16'hCABC);
    load(10'd1, 16'h0925);
    load(10'd2, 16'h092F);
    load(10'd3, 16'h9800);
    start_run();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pre_valid got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || op2_val !== 16'hABC5) begin errors++; $display("FAIL pre_add got %b/%h want 1/abc5", out_valid, op2_val); end
    checks++; if (pc_out !== 10'd1) begin errors++; $display("FAIL pre_add_pc got %h want 001", pc_out); end
    tick();
    checks++; if (op2_val !== 16'hFFFF) begin errors++; $display("FAIL pre_consumed got %h want ffff", op2_val); end
  endtask

  task automatic test_squash();
    do_reset();
    load(10'd0, 16'h0D25);
    load(10'd1, 16'h9E00);
    load(10'd2, 16'h9800);
    z = 1'b1;
    start_run();
    tick();
    checks++; if (out_valid !== 1'b1 || ir_out !== 16'hA000) begin errors++; $display("FAIL sq_ne got %b/%h want 1/a000", out_valid, ir_out); end
    z = 1'b0;
    tick();
    checks++; if (ir_out !== 16'hA000 || pc_out !== 10'd1) begin errors++; $display("FAIL sq_eq got %h@%h want a000@001", ir_out, pc_out); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL sq_halt got %b want 0", halt); end
    tick();
    checks++; if (ir_out !== 16'h9800 || halt !== 1'b0) begin errors++; $display("FAIL sq_sys got %h/%b want 9800/0", ir_out, halt); end
    tick();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL sq_final_halt got %b want 1", halt); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) load(10'(k), 16'h0911 + 16'(k));
    load(10'd4, 16'h9800);
    out_ready = 1'b1;
    start_run();
    tick();
    tick();
    checks++; if (ir_out !== 16'h0912 || pc_out !== 10'd1) begin errors++; $display("FAIL st_pre got %h@%h want 0912@001", ir_out, pc_out); end
    out_ready = 1'b0;
    imem_we = 1'b1; imem_addr = 10'd3; imem_wdata = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      imem_we = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ir_out !== 16'h0912 || pc_out !== 10'd1 || op2_val !== 16'h0002)
        begin errors++; $display("FAIL st_hold%0d got %b %h@%h op2 %h want 1 0912@001 op2 0002", k, out_valid, ir_out, pc_out, op2_val); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (ir_out !== 16'h0913 || pc_out !== 10'd2) begin errors++; $display("FAIL st_rel1 got %h@%h want 0913@002", ir_out, pc_out); end
    tick();
    checks++; if (ir_out !== 16'h0914 || pc_out !== 10'd3) begin errors++; $display("FAIL st_rel2 got %h@%h want 0914@003", ir_out, pc_out); end
    tick();
    checks++; if (ir_out !== 16'h9800 || pc_out !== 10'd4) begin errors++; $display("FAIL st_sys got %h@%h want 9800@004", ir_out, pc_out); end
  endtask

  task automatic test_forward();
    logic [15:0] exp_rd;
`ifdef FD_FORWARD_EN
    exp_rd = 16'h1234;
`else
    exp_rd = 16'h0055;
`endif
    do_reset();
    load(10'd0, 16'h0830);
    load(10'd1, 16'h08FF);
    load(10'd2, 16'h9800);
    wb_en = 1'b1; wb_dest = 4'd0;  wb_data = 16'h0007; tick();
    wb_dest = 4'd3;  wb_data = 16'h0055; tick();
    wb_dest = 4'd15; wb_data = 16'hFFFF; tick();
    wb_en = 1'b0;
    start_run();
    wb_en = 1'b1; wb_dest = 4'd3; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    checks++; if (rd_val !== exp_rd) begin errors++; $display("FAIL fwd_rd got %h want %h", rd_val, exp_rd); end
    checks++; if (op2_val !== 16'h0007) begin errors++; $display("FAIL fwd_op2 got %h want 0007", op2_val); end
    tick();
    checks++; if (rd_val !== 16'h0001 || op2_val !== 16'h0001) begin errors++; $display("FAIL pc_alias got %h/%h want 0001/0001", rd_val, op2_val); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    load(10'd0, 16'hCABC);
    load(10'd1, 16'h0925);
    load(10'd2, 16'h9800);
    start_run();
    tick();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || pc_out !== 10'd0 || ir_out !== 16'h0 || rd_val !== 16'h0 || op2_val !== 16'h0 || halt !== 1'b0)
      begin errors++; $display("FAIL mid_reset got %b %h %h %h %h %b want all zero", out_valid, pc_out, ir_out, rd_val, op2_val, halt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_idle got %b want 0", out_valid); end
    start_run();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL replay_pre got %b want 0", out_valid); end
    tick();
    checks++; if (ir_out !== 16'h0925 || pc_out !== 10'd1 || op2_val !== 16'hABC5) begin errors++; $display("FAIL replay_add got %h@%h op2 %h want 0925@001 op2 abc5", ir_out, pc_out, op2_val); end
  endtask

  initial begin
    test_reset();
    test_mov_sys();
    test_pre();
    test_squash();
    test_stall();
    test_forward();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 16: data/instruction word width (>=16).
REQ-003 Parameter IMEM_AW, default 10: instruction memory address bits; depth is 2**IMEM_AW.
REQ-004 Parameter NREGS, default 16: register count; register NREGS-1 is the PC alias.
REQ-005 Ports are clk (input, 1, clock) and reset (input, 1, synchronous active-high reset).
REQ-006 Port start (input, 1) is a pulse that leaves IDLE.
REQ-007 Ports imem_we (input, 1), imem_addr (input, IMEM_AW) and imem_wdata (input, WIDTH) form the instruction load port.
REQ-008 Port z (input, 1) is the Z flag from write-back.
REQ-009 Ports wb_en (input, 1), wb_dest (input, 4) and wb_data (input, WIDTH) form the register write-back port.
REQ-010 Port out_ready (input, 1) is downstream-ready.
REQ-011 Port out_valid (output, 1) marks a decoded instruction on the outputs.
REQ-012 Ports pc_out (output, IMEM_AW), ir_out (output, WIDTH), rd_val (output, WIDTH) and op2_val (output, WIDTH) carry the decoded instruction.
REQ-013 Port halt (output, 1) is high while the block is in HALT.

Function
REQ-014 The state machine SHALL have three states, IDLE, RUN and HALT, with transitions IDLE->RUN on start and RUN->HALT when SYS is emitted; HALT SHALL be left only by reset.
REQ-015 Instruction memory writes SHALL be accepted in IDLE and HALT only; in RUN, imem_we is ignored.
REQ-016 Advance = !out_valid | out_ready; only in RUN with advance SHALL the block read imem[PC], register the decode and increment PC modulo 2**IMEM_AW.
REQ-017 When out_valid & !out_ready, all outputs, PC and the prefix state SHALL hold unchanged.
REQ-018 Latency SHALL be one cycle: a word fetched at edge t appears on the outputs after edge t, with pc_out equal to its address.
REQ-019 Field positions: opcode = ir[15:11]; CC = ir[10:9] (0 AL, 1 S, 2 NE, 3 EQ); IMM = ir[8]; dest = ir[7:4]; op2 = ir[3:0].
REQ-020 A PRE word (ir[15:14]==2'b11) SHALL load pre <= ir[WIDTH-5:0] and set pre_flag, SHALL NOT be emitted (out_valid=0 that cycle), and SHALL still advance PC.
REQ-021 An instruction with CC=NE and z=1, or CC=EQ and z=0, SHALL be emitted as NOP (opcode 5'b10100, other bits 0); a squashed instruction SHALL NOT affect pre_flag or halt.
REQ-022 op2_val with IMM=1 SHALL be {pre, op2} when pre_flag=1, otherwise op2 sign-extended from bit 3 to WIDTH.
REQ-023 op2_val with IMM=0 SHALL be reg[op2].
REQ-024 rd_val SHALL be reg[dest].
REQ-025 A read of register NREGS-1 SHALL return the zero-extended address of that instruction.
REQ-026 pre_flag SHALL clear when an emitted, unsquashed IMM=1 instruction consumes it; a second PRE before consumption SHALL overwrite pre.
REQ-027 Write-back SHALL update reg[wb_dest] at the edge when wb_en=1, in any state.
REQ-028 Write-back to NREGS-1 SHALL be ignored.
REQ-029 An unsquashed SYS (5'b10011) SHALL be emitted with out_valid=1, and fetch SHALL stop; halt SHALL rise on the cycle after SYS is accepted by out_ready.

Reset
REQ-030 Reset SHALL force state=IDLE, PC=0, pre=0, pre_flag=0, out_valid=0, halt=0, pc_out=0, ir_out=0, rd_val=0, op2_val=0 and all registers=0.
REQ-031 Reset SHALL take priority over every other event, including a reset asserted mid-RUN with out_valid held.
REQ-032 Instruction memory contents SHALL survive reset.

Configuration
REQ-033 With FD_FORWARD_EN defined, a decode read whose register equals wb_dest while wb_en=1 SHALL return wb_data in the same cycle.
REQ-034 Without FD_FORWARD_EN, such a read SHALL return the pre-write register value.

Structure
REQ-035 Package pinky_pkg SHALL hold the opcode constants, CC encodings, field-position constants and the state enum typedef.
REQ-036 The register file SHALL be sub-module pinky_regfile (2 read ports, 1 write port, forwarding under FD_FORWARD_EN).

Verification
REQ-037 Program MOV r1,#-3 (imm 4'hD), then SYS; after start: out_valid=1 with op2_val=16'hFFFD, then the SYS word, then halt=1.
REQ-038 PRE 12'hABC then ADD r2,#5: no valid output for PRE; ADD op2_val=16'hABC5; a following IMM instruction sees sign-extended op2.
REQ-039 With z=1, a CC=NE word is emitted as 16'hA000; with z=0, a CC=EQ word is also emitted as 16'hA000 and halt stays 0.
REQ-040 Hold out_ready=0 for 3 cycles mid-stream: outputs and pc_out are stable, and no word is skipped or repeated after release.
REQ-041 wb_en=1, wb_dest=3, wb_data=16'h1234 in the cycle that ADD r3 is decoded: rd_val=16'h1234 with FD_FORWARD_EN, and the old value without it.
REQ-042 Assert reset while out_valid=0 and out_ready=0 in RUN: the next cycle shows IDLE with PC=0 and all outputs zero; after start, the same program replays from address 0.
